// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_t  : transmitter FSM states
//   DATA_BITS   : payload bits per frame (also the FIFO data width)
//   FRAME_BITS  : start + data + stop bits per 8N1 frame
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage : fifo_uart_pkg

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read port of the team's synchronous FIFO.
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO registered data_out, valid the cycle after a read pulse
//   fifo_rd_en : FIFO read_e, one-cycle pulse per byte
// master = the reader (fifo_uart_tx), slave = the FIFO.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface : fifo_uart_tx_if

// File: rtl/fifo_uart_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   i_clear : restart the period; the count is 0 on the following cycle
//   o_tick  : high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST_COUNT);
  assign o_tick = w_last;

  // NOTE: state elements are written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset || i_clear || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule : uart_baud_tick

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains the team's 8-bit synchronous FIFO one byte at a time and sends each
// byte as an 8N1 UART frame, LSB first.
//   clk           : clock, rising edge
//   reset         : synchronous, active-high
//   i_tx_enable   : allows new frames to start; a running frame always ends
//   fifo_rd       : FIFO read port (master side: empty, data in; rd_en out)
//   o_tx          : serial line, idles high (registered)
//   o_busy        : high from FETCH through STOP
//   o_frames_sent : completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tx_enable,
  fifo_uart_tx_if.master        fifo_rd,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic [7:0]            o_frames_sent
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_next_state;
  logic                 w_tick;
  logic                 w_baud_clear;
  logic                 w_busy;

  logic                 r_tx;
  logic                 r_rd_en;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_frames;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The empty flag is looked at only in IDLE, which is at
  // least two cycles after the previous pop, so it has settled by then.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (i_tx_enable && !fifo_rd.fifo_empty) w_next_state = FETCH;
      FETCH: w_next_state = LOAD;
      LOAD:  w_next_state = START;
      START: if (w_tick) w_next_state = DATA;
      DATA:  if (w_tick && (r_bit_idx == LAST_BIT)) w_next_state = STOP;
      STOP:  if (w_tick) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Decoded outputs. The baud timer restarts during LOAD so the start bit
  // gets a full period from the edge where tx falls.
  always_comb begin
    w_busy       = (r_state != IDLE);
    w_baud_clear = (r_state == LOAD);
  end

  // Datapath: read strobe, shift register, serial output and frame counter.
  // The read strobe is registered off the IDLE->FETCH decision so it is high
  // exactly while the FSM sits in FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_frames  <= '0;
    end else begin
      r_rd_en <= (w_next_state == FETCH);
      unique case (r_state)
        LOAD: begin
          r_shift <= fifo_rd.fifo_data;
          r_tx    <= 1'b0;
        end
        START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            // Next bit is shift[1] before the shift lands; after bit 7 the
            // line goes to the stop level.
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
            r_tx      <= (r_bit_idx == LAST_BIT) ? 1'b1 : r_shift[1];
          end
        end
        STOP: begin
          if (w_tick) r_frames <= r_frames + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd.fifo_rd_en = r_rd_en;
  assign o_tx               = r_tx;
  assign o_busy             = w_busy;
  assign o_frames_sent      = r_frames;

endmodule : fifo_uart_tx
